// File: rtl/osd_glyph_fetch_ctrl.sv
// osd_glyph_fetch_ctrl: prefetches one OSD glyph byte per cell ahead of the beam, shifts it out LSB-first and arbitrates char-RAM host writes; define OSD_SHADOW_EN to add the osd_shadow output
module osd_glyph_fetch_ctrl #(
  parameter int COLS    = 16,
  parameter int ROWS    = 4,
  parameter int GLYPH_H = 12,
  parameter int CADDR_W = 6,
  parameter int X0      = 40,
  parameter int Y0      = 60
) (
  input  logic               mclock,
  input  logic               reset,
  input  logic               pix_en,
  input  logic               hblank,
  input  logic               vblank,
  input  logic [8:0]         h_count,
  input  logic [8:0]         v_count,
  input  logic               osd_enable,
  output logic [CADDR_W-1:0] char_addr,
  output logic               char_we,
  output logic [6:0]         char_wdata,
  input  logic [6:0]         char_rdata,
  output logic [10:0]        font_addr,
  input  logic [7:0]         font_data,
  input  logic               wr_req,
  input  logic [CADDR_W-1:0] wr_addr,
  input  logic [6:0]         wr_data,
  output logic               wr_ack,
  output logic               osd_active,
  output logic               osd_pixel,
  output logic               underrun
`ifdef OSD_SHADOW_EN
  ,
  output logic               osd_shadow
`endif
);
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int RW = $clog2(ROWS + 1);
  localparam int GW = GLYPH_H > 1 ? $clog2(GLYPH_H) : 1;
  localparam logic [9:0] XS = 10'(X0);
  localparam logic [9:0] XE = 10'(X0 + 8 * COLS);
  localparam logic [8:0] YS = 9'(Y0);
  typedef enum logic [2:0] {IDLE, CRD, CWAIT, FRD, FWAIT, LOAD} state_t;
  state_t state_q, state_d;
  logic hblank_q;
  logic in_win_q, in_win_d;
  logic [GW-1:0] gline_q, gline_d;
  logic [RW-1:0] crow_q, crow_d;
  logic [CW-1:0] fcol_q, fcol_d, col;
  logic [6:0] code_q, code_d;
  logic [7:0] gbuf_q, gbuf_d, sh_q, sh_d, cur;
  logic buf_full_q, buf_full_d;
  logic act_q, act_d, pix_q, pix_d, und_q, und_d, blk_q, blk_d;
  logic [8:0] dx;
  logic hb_fall, hb_rise, gl_last, reload, first, start0, start1, vis, wr_go;
  always_comb begin
    hb_fall = hblank_q & ~hblank;
    hb_rise = ~hblank_q & hblank;
    gl_last = gline_q == GW'(GLYPH_H - 1);
    dx = h_count - XS[8:0];
    col = CW'(dx >> 3);
    first = dx[2:0] == 3'd0;
    reload = pix_en & in_win_q & ({1'b0, h_count} >= XS) & ({1'b0, h_count} < XE);
    start0 = hb_fall & ~vblank & (v_count >= YS) & (crow_q < RW'(ROWS));
    start1 = reload & first & (col != CW'(COLS - 1));
    in_win_d = vblank ? 1'b0 : start0 ? 1'b1 : hb_rise ? 1'b0 : in_win_q;
    gline_d = vblank ? '0 : (hb_rise & in_win_q) ? (gl_last ? '0 : gline_q + 1'b1) : gline_q;
    crow_d = vblank ? '0 : (hb_rise & in_win_q & gl_last) ? crow_q + 1'b1 : crow_q;
    fcol_d = start0 ? '0 : start1 ? col + 1'b1 : fcol_q;
    code_d = state_q == CWAIT ? char_rdata : code_q;
    gbuf_d = state_q == LOAD ? font_data : gbuf_q;
    buf_full_d = (vblank | (reload & first)) ? 1'b0 : state_q == LOAD ? 1'b1 : buf_full_q;
    cur = (reload & first) ? (buf_full_q ? gbuf_q : 8'h00) : sh_q;
    sh_d = reload ? cur >> 1 : sh_q;
    vis = reload & osd_enable;
    act_d = pix_en ? vis : act_q;
    pix_d = pix_en ? vis & cur[0] : pix_q;
    und_d = und_q | (reload & first & ~buf_full_q);
    wr_go = wr_req & ~blk_q & (state_q != CRD) & ~reset;
    blk_d = wr_go | (blk_q & wr_req);
  end
  always_comb begin
    case (state_q)
      CRD:     state_d = CWAIT;
      CWAIT:   state_d = FRD;
      FRD:     state_d = FWAIT;
      FWAIT:   state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (start0 | start1) state_d = CRD;
    if (vblank) state_d = IDLE;
  end
  always_comb begin
    char_we = wr_go;
    wr_ack = wr_go;
    char_wdata = wr_go ? wr_data : 7'd0;
    char_addr = wr_go ? wr_addr : state_q == CRD ? CADDR_W'(crow_q) * CADDR_W'(COLS) + CADDR_W'(fcol_q) : '0;
    font_addr = ({4'd0, code_q} << 3) + ({4'd0, code_q} << 2) + 11'(gline_q);
    osd_active = act_q;
    osd_pixel = pix_q;
    underrun = und_q;
  end
  always_ff @(posedge mclock) begin
    if (reset) begin
      state_q <= IDLE;
      hblank_q <= 1'b0;
      in_win_q <= 1'b0;
      gline_q <= '0;
      crow_q <= '0;
      fcol_q <= '0;
      code_q <= '0;
      gbuf_q <= '0;
      sh_q <= '0;
      buf_full_q <= 1'b0;
      act_q <= 1'b0;
      pix_q <= 1'b0;
      und_q <= 1'b0;
      blk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hblank_q <= hblank;
      in_win_q <= in_win_d;
      gline_q <= gline_d;
      crow_q <= crow_d;
      fcol_q <= fcol_d;
      code_q <= code_d;
      gbuf_q <= gbuf_d;
      sh_q <= sh_d;
      buf_full_q <= buf_full_d;
      act_q <= act_d;
      pix_q <= pix_d;
      und_q <= und_d;
      blk_q <= blk_d;
    end
  end
`ifdef OSD_SHADOW_EN
  logic pd_q, pd_d, shd_q, shd_d, pd_eff;
  always_comb begin
    pd_eff = (reload & first & (col == '0)) ? 1'b0 : pd_q;
    pd_d = reload ? cur[0] : pd_q;
    shd_d = pix_en ? vis & pd_eff & ~cur[0] : shd_q;
    osd_shadow = shd_q;
  end
  always_ff @(posedge mclock) begin
    if (reset) begin
      pd_q <= 1'b0;
      shd_q <= 1'b0;
    end else begin
      pd_q <= pd_d;
      shd_q <= shd_d;
    end
  end
`endif
endmodule
